ecc_host_bridge: RTL and testbench
==================================

Name: ecc_host_bridge

Overview:
- Host-side bridge that sits directly upstream and downstream of the ECC point-multiply wrapper.
- Accepts one parallel request (curve + point + multiplier) by valid/ready and drives the wrapper's bit-serial input protocol.
- Collects the wrapper's bit-serial result (o_data_valid, o_Pointx, o_Pointy) and presents it as parallel words by valid/ready.
- Allows exactly one outstanding operation.

Parameters:
- MAX_BITS, 128, width of all parallel operand/result buses; must be ≥128.
- CNT_W, 8, width of the bit counters; must satisfy 2^CNT_W > MAX_BITS.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request offered
- req_ready  out  1  bridge accepts request this cycle
- req_kind  in  1  0=FULL (mode, a, prime, point, mul); 1=POINT (point, mul; curve reused)
- req_mode  in  2  operand width code, FULL only
- req_a, req_prime, req_px, req_py, req_mul  in  MAX_BITS each  operands, right-aligned
- s_data_valid  out  1  to wrapper i_data_valid
- s_mode  out  1  to wrapper i_mode
- s_a, s_prime, s_px, s_py, s_mul  out  1 each  to wrapper i_a, i_prime, i_Pointx, i_Pointy, i_mul
- s_res_valid, s_res_x, s_res_y  in  1 each  from wrapper o_data_valid, o_Pointx, o_Pointy
- res_valid  out  1  result available
- res_ready  in  1  host consumes result
- res_x, res_y  out  MAX_BITS each  result, right-aligned, upper bits zero
- err  out  1  sticky error; cleared only by rst

Behaviour:
- Reset: all outputs 0; latched mode = BITS32; both FSMs idle; outstanding flag 0.
- W from latched mode: BITS16=00→16, BITS32=01→32, BITS64=10→64, BITS128=11→128.
- A FULL request latches the new mode at acceptance.
- All s_* outputs are registered. s_a, s_prime and s_mode are 0 whenever not actively carrying a bit.
- req_ready = TX in T_IDLE && outstanding==0 && RX in R_IDLE.
- TX FSM (acceptance at cycle T):
  - T_IDLE → T_VALID on accept.
  - T_VALID: s_data_valid=1 at T+1, one cycle only.
  - T_MODE (FULL only): s_mode = mode[1] at T+2, mode[0] at T+3.
  - T_DATA: W bits, MSB first (operand bit W-1 first).
    - FULL: cycles T+4..T+3+W on s_a, s_prime, s_px, s_py, s_mul.
    - POINT: cycles T+2..T+1+W on s_px, s_py, s_mul only; s_a and s_prime held 0.
  - After the last data bit: set outstanding=1, return to T_IDLE.
  - Bits above W in the request words are ignored.
- RX FSM:
  - R_IDLE → R_SHIFT when s_res_valid=1. That cycle's bits are the MSBs and are captured.
  - R_SHIFT: shift {s_res_x, s_res_y} in each cycle for W total bits (cycles R..R+W-1).
    - If s_res_valid drops before W bits are captured: set err, discard partial data, return to R_IDLE, keep outstanding.
  - R_HOLD: res_valid=1 from cycle R+W; res_x/res_y stable.
    - On res_valid && res_ready: res_valid=0 next cycle, outstanding cleared, → R_IDLE.
    - s_res_valid=1 during R_HOLD: set err, ignore the bits, keep the held result.
- s_res_valid while outstanding==0 (unsolicited) is still captured normally; it does not set err.
- Simultaneous req_valid and res_ready in the same cycle: result is consumed; the request is accepted no earlier than the next cycle.
- rst mid-operation: both FSMs abort immediately. The s_* lines are 0 next cycle. No partial result is emitted.

Decomposition:
- Package ecc_pkg:
  - width codes BITS16/32/64/128;
  - MAX_BITS default;
  - req_kind encodings FULL/POINT;
  - function mode_to_width (code → W).
- Sub-module ecc_ser_shift: parameterised MSB-first parallel-in/serial-out shifter with a down-counter and done flag. Instantiate once per operand group in TX.
- RX deserializer stays inline.

Test Plan:
- FULL, mode=00, a=0x0002, prime=0x0061, px=0x0003, py=0x0006, mul=0x0005, accepted at T → s_data_valid=1 only at T+1; s_mode=0,0 at T+2,T+3; s_prime=0000000001100001 over T+4..T+19; req_ready=0 from T+1 until result consumed.
- POINT after previous FULL, px=0x000A, py=0x0011, mul=0x0003 → s_px bits start T+2 (0000000000001010), 16 bits; s_a=s_prime=0 throughout.
- Result burst of 16 cycles, x=0x0050, y=0x0022 at R..R+15 → res_valid=1 at R+16, res_x=0x…0050, res_y=0x…0022; res_ready held low 5 cycles keeps values; res_ready=1 clears res_valid next cycle.
- FULL mode=11, 128-bit all-ones mul → exactly 128 ones on s_mul over T+4..T+131, then 0.
- Burst truncated after 7 bits → err=1 sticky, no res_valid, req_ready stays 0; next full 16-bit burst yields res_valid.
- rst asserted at T+10 of a 64-bit send → next cycle all s_*=0, req_ready=1, latched mode=BITS32 (a POINT request then sends 32 bits).

Source files
------------

// File: rtl/ecc_pkg.sv
// ecc_pkg: shared definitions for the ECC host bridge.
//   - operand width codes carried on the wrapper's serial mode line
//   - request kind encodings (FULL curve load vs POINT-only reuse)
//   - default bus / counter widths
//   - mode_to_width(): width code -> number of serial bits per operand
package ecc_pkg;

  localparam int MAX_BITS_DEFAULT = 128;
  localparam int CNT_W_DEFAULT    = 8;

  typedef enum logic [1:0] {
    BITS16  = 2'b00,
    BITS32  = 2'b01,
    BITS64  = 2'b10,
    BITS128 = 2'b11
  } width_code_e;

  typedef enum logic {
    REQ_FULL  = 1'b0,
    REQ_POINT = 1'b1
  } req_kind_e;

  function automatic int unsigned mode_to_width(input width_code_e code);
    case (code)
      BITS16:  return 16;
      BITS32:  return 32;
      BITS64:  return 64;
      default: return 128;
    endcase
  endfunction

endpackage

// File: rtl/ecc_ser_shift.sv
// ecc_ser_shift: MSB-first parallel-in / serial-out shifter for LANES operands
// that are always sent together with the same bit count.
//   clk, rst    clock, synchronous active-high reset
//   load        capture load_data and load_width (has priority over shift)
//   load_width  number of bits W to send per lane (bits above W are dropped)
//   load_data   LANES words of WIDTH bits, lane l at [l*WIDTH +: WIDTH]
//   shift       advance every lane by one bit
//   bits        current bit of each lane (operand bit W-1 right after load)
//   done        all W bits of the loaded words have been shifted out
module ecc_ser_shift #(
  parameter int WIDTH = 128,
  parameter int LANES = 1,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic [CNT_W-1:0]       load_width,
  input  logic [LANES*WIDTH-1:0] load_data,
  input  logic                   shift,
  output logic [LANES-1:0]       bits,
  output logic                   done
);

  logic [WIDTH-1:0] data [LANES];
  logic [CNT_W-1:0] cnt;

  // Words are left-aligned on load so operand bit W-1 sits at the MSB and
  // every later bit is reached by a plain left shift.
  // NOTE: the data words carry no reset; cnt is reset and done/the FSM above
  // never look at data until a load has refilled it, so resetting the wide
  // array would only cost routing.
  always_ff @(posedge clk) begin
    if (load) begin
      for (int l = 0; l < LANES; l++) begin
        data[l] <= load_data[l*WIDTH +: WIDTH] << (WIDTH - int'(load_width));
      end
    end else if (shift) begin
      for (int l = 0; l < LANES; l++) begin
        data[l] <= data[l] << 1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples the pre-edge value of its neighbours regardless of the
  // order the statements are written in.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_width;
    end else if (shift && cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  // NOTE: combinational outputs get a default before the loop so no path
  // leaves them unassigned, which would otherwise infer a latch.
  always_comb begin
    bits = '0;
    for (int l = 0; l < LANES; l++) begin
      bits[l] = data[l][WIDTH-1];
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/ecc_host_bridge.sv
// ecc_host_bridge: host-side bridge around the bit-serial ECC point-multiply
// wrapper. One parallel request is accepted by valid/ready, serialised onto
// the wrapper input lines, and the wrapper's serial result is collected back
// into parallel words offered by valid/ready. One operation may be in flight.
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   req_valid / req_ready          request handshake
//   req_kind                       0 = FULL (mode, a, prime, point, mul),
//                                  1 = POINT (point, mul; curve reused)
//   req_mode                       width code, taken on FULL requests only
//   req_a, req_prime, req_px,
//   req_py, req_mul                right-aligned operands
//   s_data_valid, s_mode, s_a,
//   s_prime, s_px, s_py, s_mul     registered serial lines to the wrapper
//   s_res_valid, s_res_x, s_res_y  serial result from the wrapper
//   res_valid / res_ready          result handshake
//   res_x, res_y                   right-aligned result, upper bits zero
//   err                            sticky protocol error, cleared by rst
module ecc_host_bridge
  import ecc_pkg::*;
#(
  parameter int MAX_BITS = MAX_BITS_DEFAULT,
  parameter int CNT_W    = CNT_W_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_kind,
  input  logic [1:0]          req_mode,
  input  logic [MAX_BITS-1:0] req_a,
  input  logic [MAX_BITS-1:0] req_prime,
  input  logic [MAX_BITS-1:0] req_px,
  input  logic [MAX_BITS-1:0] req_py,
  input  logic [MAX_BITS-1:0] req_mul,
  output logic                s_data_valid,
  output logic                s_mode,
  output logic                s_a,
  output logic                s_prime,
  output logic                s_px,
  output logic                s_py,
  output logic                s_mul,
  input  logic                s_res_valid,
  input  logic                s_res_x,
  input  logic                s_res_y,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [MAX_BITS-1:0] res_x,
  output logic [MAX_BITS-1:0] res_y,
  output logic                err
);

  // Each state names what the serial lines carry while it is current.
  typedef enum logic [2:0] {
    T_IDLE,
    T_VALID,    // s_data_valid pulse on the lines
    T_MODE_HI,  // mode[1] on s_mode
    T_MODE_LO,  // mode[0] on s_mode
    T_DATA      // operand bits on the data lines
  } tx_state_e;

  typedef enum logic [1:0] {
    R_IDLE,
    R_SHIFT,
    R_HOLD
  } rx_state_e;

  tx_state_e   tx_state;
  rx_state_e   rx_state;
  width_code_e mode_q;
  width_code_e load_code;
  logic        kind_point_q;
  logic        outstanding;

  logic [CNT_W-1:0] cur_width;
  logic [CNT_W-1:0] load_width;
  logic [CNT_W-1:0] rx_cnt;
  logic [CNT_W-1:0] rx_cnt_next;

  logic [MAX_BITS-1:0] rx_x;
  logic [MAX_BITS-1:0] rx_y;
  logic [MAX_BITS-1:0] rx_x_next;
  logic [MAX_BITS-1:0] rx_y_next;

  logic       accept;
  logic       tx_emit;
  logic       tx_last;
  logic       consume;
  logic [2:0] pt_bits;
  logic [1:0] cv_bits;
  logic       pt_done;
  logic       cv_done;

  assign req_ready = (tx_state == T_IDLE) && !outstanding && (rx_state == R_IDLE);
  assign accept    = req_valid && req_ready;
  assign consume   = res_valid && res_ready;

  // A FULL request brings its own width; POINT reuses the latched one.
  always_comb begin
    load_code = mode_q;
    if (req_kind == REQ_FULL) begin
      load_code = width_code_e'(req_mode);
    end
  end

  assign load_width = CNT_W'(mode_to_width(load_code));
  assign cur_width  = CNT_W'(mode_to_width(mode_q));

  // The curve shifter is loaded only by FULL requests, so on POINT its done
  // flag is stale and the point group alone decides the end of the stream.
  assign tx_last = pt_done && (kind_point_q || cv_done);

  // Cycles whose next edge puts a fresh operand bit on the lines: the edge
  // into T_DATA, and every T_DATA edge until the shifters run dry.
  assign tx_emit = (tx_state == T_VALID && kind_point_q) ||
                   (tx_state == T_MODE_LO) ||
                   (tx_state == T_DATA && !tx_last);

  ecc_ser_shift #(
    .WIDTH (MAX_BITS),
    .LANES (3),
    .CNT_W (CNT_W)
  ) u_point_shift (
    .clk        (clk),
    .rst        (rst),
    .load       (accept),
    .load_width (load_width),
    .load_data  ({req_px, req_py, req_mul}),
    .shift      (tx_emit),
    .bits       (pt_bits),
    .done       (pt_done)
  );

  ecc_ser_shift #(
    .WIDTH (MAX_BITS),
    .LANES (2),
    .CNT_W (CNT_W)
  ) u_curve_shift (
    .clk        (clk),
    .rst        (rst),
    .load       (accept && (req_kind == REQ_FULL)),
    .load_width (load_width),
    .load_data  ({req_a, req_prime}),
    .shift      (tx_emit && !kind_point_q),
    .bits       (cv_bits),
    .done       (cv_done)
  );

  // Transmit FSM. Every serial line defaults to 0 each cycle and is raised
  // only in the cycle it actually carries a bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state     <= T_IDLE;
      mode_q       <= BITS32;
      kind_point_q <= 1'b0;
      s_data_valid <= 1'b0;
      s_mode       <= 1'b0;
      s_a          <= 1'b0;
      s_prime      <= 1'b0;
      s_px         <= 1'b0;
      s_py         <= 1'b0;
      s_mul        <= 1'b0;
    end else begin
      s_data_valid <= 1'b0;
      s_mode       <= 1'b0;
      s_a          <= 1'b0;
      s_prime      <= 1'b0;
      s_px         <= 1'b0;
      s_py         <= 1'b0;
      s_mul        <= 1'b0;

      if (tx_emit) begin
        s_px  <= pt_bits[2];
        s_py  <= pt_bits[1];
        s_mul <= pt_bits[0];
        if (!kind_point_q) begin
          s_a     <= cv_bits[1];
          s_prime <= cv_bits[0];
        end
      end

      case (tx_state)
        T_IDLE: begin
          if (accept) begin
            s_data_valid <= 1'b1;
            kind_point_q <= req_kind;
            if (req_kind == REQ_FULL) begin
              mode_q <= width_code_e'(req_mode);
            end
            tx_state <= T_VALID;
          end
        end
        T_VALID: begin
          if (kind_point_q) begin
            tx_state <= T_DATA;
          end else begin
            s_mode   <= mode_q[1];
            tx_state <= T_MODE_HI;
          end
        end
        T_MODE_HI: begin
          s_mode   <= mode_q[0];
          tx_state <= T_MODE_LO;
        end
        T_MODE_LO: tx_state <= T_DATA;
        T_DATA: begin
          if (tx_last) begin
            tx_state <= T_IDLE;
          end
        end
        default: tx_state <= T_IDLE;
      endcase
    end
  end

  assign rx_x_next   = {rx_x[MAX_BITS-2:0], s_res_x};
  assign rx_y_next   = {rx_y[MAX_BITS-2:0], s_res_y};
  assign rx_cnt_next = rx_cnt + CNT_W'(1);

  // Receive FSM plus the outstanding flag. A finished send and a consumed
  // result can land on the same edge (unsolicited result being drained while
  // a new operation goes out); the new operation wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state    <= R_IDLE;
      rx_cnt      <= '0;
      rx_x        <= '0;
      rx_y        <= '0;
      res_valid   <= 1'b0;
      res_x       <= '0;
      res_y       <= '0;
      err         <= 1'b0;
      outstanding <= 1'b0;
    end else begin
      if (tx_state == T_DATA && tx_last) begin
        outstanding <= 1'b1;
      end else if (consume) begin
        outstanding <= 1'b0;
      end

      case (rx_state)
        R_IDLE: begin
          if (s_res_valid) begin
            rx_x     <= {{(MAX_BITS-1){1'b0}}, s_res_x};
            rx_y     <= {{(MAX_BITS-1){1'b0}}, s_res_y};
            rx_cnt   <= CNT_W'(1);
            rx_state <= R_SHIFT;
          end
        end
        R_SHIFT: begin
          if (!s_res_valid) begin
            // Truncated burst: drop the partial word, keep waiting.
            err      <= 1'b1;
            rx_state <= R_IDLE;
          end else begin
            rx_x   <= rx_x_next;
            rx_y   <= rx_y_next;
            rx_cnt <= rx_cnt_next;
            if (rx_cnt_next == cur_width) begin
              res_x     <= rx_x_next;
              res_y     <= rx_y_next;
              res_valid <= 1'b1;
              rx_state  <= R_HOLD;
            end
          end
        end
        R_HOLD: begin
          if (s_res_valid) begin
            err <= 1'b1;
          end
          if (res_ready) begin
            res_valid <= 1'b0;
            rx_state  <= R_IDLE;
          end
        end
        default: rx_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ecc_host_bridge.sv
// Self-checking bench for ecc_host_bridge: a table of full transactions,
// randomized transactions, and hand-written protocol corner cases. Expected
// serial streams are derived per cycle from operand bit positions.
module tb_ecc_host_bridge;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic         req_kind = 1'b0;
  logic [1:0]   req_mode = 2'b00;
  logic [127:0] req_a = '0, req_prime = '0, req_px = '0, req_py = '0, req_mul = '0;
  logic         s_data_valid, s_mode, s_a, s_prime, s_px, s_py, s_mul;
  logic         s_res_valid = 1'b0, s_res_x = 1'b0, s_res_y = 1'b0;
  logic         res_valid;
  logic         res_ready = 1'b0;
  logic [127:0] res_x, res_y;
  logic         err;

  int checks   = 0;
  int failures = 0;

  // Width code the bridge should currently hold (reset value BITS32).
  logic [1:0] model_mode = 2'b01;

  ecc_host_bridge #(.MAX_BITS(128), .CNT_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_kind     (req_kind),
    .req_mode     (req_mode),
    .req_a        (req_a),
    .req_prime    (req_prime),
    .req_px       (req_px),
    .req_py       (req_py),
    .req_mul      (req_mul),
    .s_data_valid (s_data_valid),
    .s_mode       (s_mode),
    .s_a          (s_a),
    .s_prime      (s_prime),
    .s_px         (s_px),
    .s_py         (s_py),
    .s_mul        (s_mul),
    .s_res_valid  (s_res_valid),
    .s_res_x      (s_res_x),
    .s_res_y      (s_res_y),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_x        (res_x),
    .res_y        (res_y),
    .err          (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         kind;
    logic [1:0]   mode;
    logic [127:0] a, p, x, y, mu;
    logic [127:0] rx, ry;
    int           hold;
  } vec_t;

  vec_t vecs[5];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int width_of(input logic [1:0] m);
    return 16 << m;
  endfunction

  function automatic logic [127:0] wmask(input int w);
    if (w >= 128) return '1;
    return (128'd1 << w) - 128'd1;
  endfunction

  function automatic logic [6:0] s_bus();
    return {s_data_valid, s_mode, s_a, s_prime, s_px, s_py, s_mul};
  endfunction

  // Expected {dv, mode, a, prime, px, py, mul} at cycle T+k after acceptance.
  function automatic logic [6:0] tx_exp(input logic kind, input logic [1:0] m,
                                        input logic [127:0] a, p, x, y, mu, input int k);
    int w;
    int base;
    int b;
    logic [6:0] r;
    w    = width_of(m);
    base = kind ? 2 : 4;
    r    = '0;
    if (k == 1) begin
      r[6] = 1'b1;
    end else if (!kind && k == 2) begin
      r[5] = m[1];
    end else if (!kind && k == 3) begin
      r[5] = m[0];
    end else if (k >= base && k < base + w) begin
      b = w - 1 - (k - base);
      if (!kind) begin
        r[4] = a[b];
        r[3] = p[b];
      end
      r[2] = x[b];
      r[1] = y[b];
      r[0] = mu[b];
    end
    return r;
  endfunction

  task automatic wait_ready();
    int n;
    n = 0;
    while (!req_ready && n < 50) begin
      step();
      n++;
    end
    check("req_ready_wait", req_ready, 1'b1);
  endtask

  task automatic send(input logic kind, input logic [1:0] m,
                      input logic [127:0] a, p, x, y, mu);
    int len;
    wait_ready();
    req_valid = 1'b1;
    req_kind  = kind;
    req_mode  = m;
    req_a     = a;
    req_prime = p;
    req_px    = x;
    req_py    = y;
    req_mul   = mu;
    if (!kind) model_mode = m;
    step();
    req_valid = 1'b0;
    len = (kind ? 1 : 3) + width_of(model_mode);
    for (int k = 1; k <= len + 1; k++) begin
      check("tx_stream", s_bus(), tx_exp(kind, model_mode, a, p, x, y, mu, k));
      check("req_ready_busy", req_ready, 1'b0);
      if (k <= len) step();
    end
  endtask

  task automatic burst(input logic [127:0] x, y, input int nbits);
    int w;
    w = width_of(model_mode);
    for (int i = 0; i < nbits; i++) begin
      s_res_valid = 1'b1;
      s_res_x     = x[w-1-i];
      s_res_y     = y[w-1-i];
      step();
    end
    s_res_valid = 1'b0;
    s_res_x     = 1'b0;
    s_res_y     = 1'b0;
  endtask

  task automatic consume(input logic [127:0] ex, ey, input int hold);
    for (int i = 0; i < hold; i++) begin
      check("hold_valid", res_valid, 1'b1);
      check("hold_x", res_x, ex);
      check("hold_y", res_y, ey);
      step();
    end
    check("res_valid_pre", res_valid, 1'b1);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    check("res_valid_cleared", res_valid, 1'b0);
    check("req_ready_after", req_ready, 1'b1);
  endtask

  task automatic run_txn(input vec_t v);
    logic [127:0] m;
    send(v.kind, v.mode, v.a, v.p, v.x, v.y, v.mu);
    burst(v.rx, v.ry, width_of(model_mode));
    m = wmask(width_of(model_mode));
    check("res_valid_set", res_valid, 1'b1);
    check("res_x", res_x, v.rx & m);
    check("res_y", res_y, v.ry & m);
    consume(v.rx & m, v.ry & m, v.hold);
  endtask

  initial begin
    vec_t rv;

    vecs[0] = '{kind: 1'b0, mode: 2'b00, a: 128'h2, p: 128'h61, x: 128'h3, y: 128'h6,
                mu: 128'h5, rx: 128'h50, ry: 128'h22, hold: 5};
    vecs[1] = '{kind: 1'b1, mode: 2'b11, a: '0, p: '0, x: 128'hA, y: 128'h11,
                mu: 128'h3, rx: 128'hDEAD_0000_0000_0000_0000_0000_0000_1234,
                ry: 128'hFFFF_FFFF_0000_0000_0000_0000_0000_8001, hold: 0};
    vecs[2] = '{kind: 1'b0, mode: 2'b11, a: 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210,
                p: 128'h8000_0000_0000_0000_0000_0000_0000_0001,
                x: 128'hA5A5_A5A5_5A5A_5A5A_0F0F_0F0F_F0F0_F0F0,
                y: 128'h1, mu: '1, rx: '1,
                ry: 128'h8000_0000_0000_0000_0000_0000_0000_0000, hold: 1};
    vecs[3] = '{kind: 1'b0, mode: 2'b10, a: 128'hFFFF_0000_1111_2222_3333_4444_5555_6666,
                p: 128'hAAAA_BBBB_CCCC_DDDD_8765_4321_0FED_CBA9,
                x: 128'h1234_5678_9ABC_DEF0_8000_0000_0000_0001, y: '1,
                mu: 128'h0000_0000_0000_0000_C000_0000_0000_0003,
                rx: 128'h7777_7777_F00D_CAFE_8000_0000_0000_0001,
                ry: 128'hBEEF_0000_1234_5678_9ABC_DEF0_0000_0000, hold: 2};
    vecs[4] = '{kind: 1'b0, mode: 2'b01, a: 128'hFFFF_FFFF_8000_0001,
                p: 128'h1_FFFF_FFFF, x: 128'h8765_4321, y: 128'hAAAA_5555,
                mu: 128'hF_8000_0000, rx: 128'h1_8000_0001, ry: 128'h0000_FFFF, hold: 3};

    // Reset state.
    step(); step(); step();
    rst = 1'b0;
    step();
    check("reset_s_bus", s_bus(), 7'd0);
    check("reset_res_valid", res_valid, 1'b0);
    check("reset_res_x", res_x, '0);
    check("reset_err", err, 1'b0);
    check("reset_req_ready", req_ready, 1'b1);

    // Table-driven transactions.
    foreach (vecs[i]) run_txn(vecs[i]);

    // Randomized transactions.
    for (int n = 0; n < 12; n++) begin
      rv.kind = 1'($urandom_range(0, 1));
      rv.mode = 2'($urandom_range(0, 3));
      rv.a    = {$urandom, $urandom, $urandom, $urandom};
      rv.p    = {$urandom, $urandom, $urandom, $urandom};
      rv.x    = {$urandom, $urandom, $urandom, $urandom};
      rv.y    = {$urandom, $urandom, $urandom, $urandom};
      rv.mu   = {$urandom, $urandom, $urandom, $urandom};
      rv.rx   = {$urandom, $urandom, $urandom, $urandom};
      rv.ry   = {$urandom, $urandom, $urandom, $urandom};
      rv.hold = int'($urandom_range(0, 3));
      run_txn(rv);
    end

    // Unsolicited result: captured normally, no error.
    burst(128'h1357_9BDF, 128'h2468_ACE0, width_of(model_mode));
    check("unsol_valid", res_valid, 1'b1);
    check("unsol_x", res_x, 128'h1357_9BDF & wmask(width_of(model_mode)));
    check("unsol_err", err, 1'b0);
    check("unsol_req_ready", req_ready, 1'b0);

    // Request offered in the same cycle the result is consumed: not accepted.
    req_valid = 1'b1;
    req_kind  = 1'b1;
    res_ready = 1'b1;
    step();
    req_valid = 1'b0;
    res_ready = 1'b0;
    check("simul_res_valid", res_valid, 1'b0);
    check("simul_no_accept", s_data_valid, 1'b0);
    check("simul_req_ready", req_ready, 1'b1);

    // Truncated burst sets sticky err; a later full burst still completes.
    send(1'b0, 2'b00, 128'h2, 128'h61, 128'h3, 128'h6, 128'h5);
    burst(128'h50, 128'h22, 7);
    step();
    check("trunc_err", err, 1'b1);
    check("trunc_res_valid", res_valid, 1'b0);
    check("trunc_req_ready", req_ready, 1'b0);
    burst(128'h50, 128'h22, 16);
    check("retry_res_valid", res_valid, 1'b1);
    check("retry_res_x", res_x, 128'h50);
    check("retry_res_y", res_y, 128'h22);
    consume(128'h50, 128'h22, 1);
    check("err_sticky", err, 1'b1);

    // Reset in the middle of a 64-bit send.
    wait_ready();
    req_valid = 1'b1;
    req_kind  = 1'b0;
    req_mode  = 2'b10;
    req_a     = '1;
    req_prime = '1;
    req_px    = '1;
    req_py    = '1;
    req_mul   = '1;
    model_mode = 2'b10;
    step();
    req_valid = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      check("pre_rst_stream", s_bus(), tx_exp(1'b0, 2'b10, '1, '1, '1, '1, '1, k));
      if (k < 10) step();
    end
    rst = 1'b1;
    step();
    check("rst_s_bus", s_bus(), 7'd0);
    check("rst_req_ready", req_ready, 1'b1);
    rst = 1'b0;
    model_mode = 2'b01;
    check("rst_err", err, 1'b0);
    check("rst_res_valid", res_valid, 1'b0);
    send(1'b1, 2'b00, '0, '0, 128'hFFFF_FFFF_8000_0001, 128'hC3C3_3C3C, 128'h1_0000_0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
